// File: rtl/packet_forwarder.sv
// Streams a packet out of the VM forwarder port as 64-bit AXI4-Stream.
// A 2-entry prefetch FIFO hides the one-cycle read latency and absorbs tready stalls.
module packet_forwarder #(
    parameter int unsigned SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH           = 64
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,
    input  logic                            ready_for_forwarder,
    input  logic [SNOOP_FWD_ADDR_WIDTH-1:0] len_to_forwarder,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0] forwarder_rd_addr,
    output logic                            forwarder_rd_en,
    input  logic [DATA_WIDTH-1:0]           forwarder_rd_data,
    output logic                            forwarder_done,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [31:0]                     packets_forwarded
);

    localparam int unsigned AW = SNOOP_FWD_ADDR_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_len_q;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_tx_cnt;
    logic [AW-1:0] r_addr_last;
    logic          r_inflight;
    logic [DW-1:0] r_fifo [2];
    logic          r_wr_idx;
    logic          r_rd_idx;
    logic [1:0]    r_count;
    logic [31:0]   r_pkt_cnt;

    logic          w_start;
    logic          w_pop;
    logic          w_push;
    logic          w_rd_en;
    logic          w_last_beat;
    logic          w_done;
    logic [2:0]    w_occ;

    assign w_start     = (r_state == S_IDLE) && ready_for_forwarder;
    assign w_pop       = m_axis_tvalid && m_axis_tready;
    assign w_push      = r_inflight;
    assign w_last_beat = (r_tx_cnt == (r_len_q - AW'(1)));
    assign w_done      = (r_state == S_DONE);

    // Occupancy after this cycle's pop, counting the read whose data lands next cycle.
    assign w_occ   = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_rd_en = (r_state == S_STREAM) && (r_rd_ptr < r_len_q) && (w_occ < 3'd2);

    assign forwarder_rd_en   = w_rd_en;
    assign forwarder_rd_addr = w_rd_en ? r_rd_ptr : r_addr_last;
    assign forwarder_done    = w_done;
    assign m_axis_tvalid     = (r_count != 2'd0);
    assign m_axis_tdata      = r_fifo[r_rd_idx];
    assign m_axis_tlast      = m_axis_tvalid && w_last_beat;
    assign packets_forwarded = r_pkt_cnt;

    // State register
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (ready_for_forwarder) begin
                    w_state_nxt = (len_to_forwarder == AW'(0)) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_pop && w_last_beat) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_HOLD;
            S_HOLD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Packet length, read pointer and beat counter
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_len_q     <= '0;
            r_rd_ptr    <= '0;
            r_tx_cnt    <= '0;
            r_addr_last <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_start) begin
                r_len_q  <= len_to_forwarder;
                r_rd_ptr <= '0;
                r_tx_cnt <= '0;
            end else begin
                if (w_rd_en) begin
                    r_rd_ptr    <= r_rd_ptr + AW'(1);
                    r_addr_last <= r_rd_ptr;
                end
                if (w_pop) begin
                    r_tx_cnt <= r_tx_cnt + AW'(1);
                end
            end
        end
    end

    // Prefetch FIFO; write and pop in one cycle leave the count unchanged
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_idx  <= 1'b0;
            r_rd_idx  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_idx] <= forwarder_rd_data;
                r_wr_idx         <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Completed-packet counter, wraps naturally at 32 bits
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_pkt_cnt <= '0;
        end else begin
            r_pkt_cnt <= r_pkt_cnt + 32'(w_done);
        end
    end

endmodule

// File: tb/tb_packet_forwarder.sv
// Scoreboard bench for packet_forwarder: stimulus queues expected reads/beats,
// a forked monitor pops and compares them as the DUT presents them.
module tb_packet_forwarder;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic [8:0]  len_in;
    logic [8:0]  rd_addr;
    logic        rd_en;
    logic [63:0] rd_data;
    logic        fwd_done;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [31:0] pkt_cnt;

    packet_forwarder #(
        .SNOOP_FWD_ADDR_WIDTH(9),
        .DATA_WIDTH(64)
    ) dut (
        .axi_aclk            (clk),
        .axi_aresetn         (rst_n),
        .ready_for_forwarder (ready),
        .len_to_forwarder    (len_in),
        .forwarder_rd_addr   (rd_addr),
        .forwarder_rd_en     (rd_en),
        .forwarder_rd_data   (rd_data),
        .forwarder_done      (fwd_done),
        .m_axis_tdata        (tdata),
        .m_axis_tvalid       (tvalid),
        .m_axis_tlast        (tlast),
        .m_axis_tready       (tready),
        .packets_forwarded   (pkt_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [8:0] addr;
        int         cyc;
    } addr_t;

    beat_t       q_beat[$];
    addr_t       q_addr[$];
    logic [63:0] tb_mem [512];
    int          cyc;
    int          n_tests;
    int          n_fail;
    int          done_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // VM buffer model: data valid the cycle after rd_en
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= tb_mem[rd_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        beat_t       b;
        addr_t       a;
        logic        pop;
        int          out_n;
        logic        stall;
        logic [63:0] sdata;
        logic        slast;
        out_n = 0;
        stall = 1'b0;
        sdata = '0;
        slast = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                out_n = 0;
                stall = 1'b0;
            end else begin
                pop = tvalid && tready;
                if (stall) begin
                    chk("stall_valid", 64'(tvalid), 64'd1);
                    chk("stall_data", tdata, sdata);
                    chk("stall_last", 64'(tlast), 64'(slast));
                end
                if (fwd_done) done_cnt++;
                if (rd_en) begin
                    n_tests++;
                    if (out_n + 1 - int'(pop) > 2) begin
                        n_fail++;
                        $display("FAIL outstanding: got %0d, expected <= 2", out_n + 1 - int'(pop));
                    end
                    if (q_addr.size() == 0) begin
                        chk("unexpected_rd_en", 64'(rd_addr), 64'h1_0000);
                    end else begin
                        a = q_addr.pop_front();
                        chk("rd_addr", 64'(rd_addr), 64'(a.addr));
                        if (a.cyc >= 0) chk("rd_cycle", 64'(cyc), 64'(a.cyc));
                    end
                end
                if (pop) begin
                    if (q_beat.size() == 0) begin
                        chk("unexpected_beat", tdata, 64'hDEAD_BEEF_DEAD_BEEF);
                    end else begin
                        b = q_beat.pop_front();
                        chk("tdata", tdata, b.data);
                        chk("tlast", 64'(tlast), 64'(b.last));
                        if (b.cyc >= 0) chk("beat_cycle", 64'(cyc), 64'(b.cyc));
                    end
                end
                out_n = out_n + int'(rd_en) - int'(pop);
                stall = tvalid && !tready;
                sdata = tdata;
                slast = tlast;
            end
        end
    endtask

    function automatic logic tr_pat(input int mode, input int k);
        if (mode == 0) return 1'b1;
        return (k % 4 == 0) || (k % 4 == 3);
    endfunction

    // mode 0: tready held high (exact timing checked); mode 1: 1,0,0,1 backpressure
    task automatic run_pkt(input logic [8:0] len, input logic [63:0] pat, input int mode,
                           input logic [31:0] exp_cnt);
        int    t0;
        bit    seen;
        beat_t b;
        addr_t a;
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < int'(len); i++) begin
            tb_mem[i] = pat + 64'h11 * 64'(i + 1);
            a.addr = 9'(i);
            a.cyc  = (mode == 0) ? t0 + 1 + i : -1;
            q_addr.push_back(a);
            b.data = tb_mem[i];
            b.last = (i == int'(len) - 1);
            b.cyc  = (mode == 0) ? t0 + 3 + i : -1;
            q_beat.push_back(b);
        end
        ready  = 1'b1;
        len_in = len;
        tready = tr_pat(mode, 0);
        seen   = 1'b0;
        for (int k = 1; k <= 300 && !seen; k++) begin
            @(negedge clk);
            if (k == 2) len_in = ~len;
            tready = tr_pat(mode, k);
            if (fwd_done) begin
                seen  = 1'b1;
                ready = 1'b0;
                if (mode == 0)
                    chk("done_cycle", 64'(cyc), 64'((len == 9'd0) ? t0 + 1 : t0 + int'(len) + 3));
                chk("beats_left_at_done", 64'(q_beat.size()), 64'd0);
            end
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        ready = 1'b0;
        @(negedge clk);
        chk("done_is_pulse", 64'(fwd_done), 64'd0);
        chk("packets_forwarded", 64'(pkt_cnt), 64'(exp_cnt));
    endtask

    initial begin
        int t0;
        int dc;
        beat_t b;
        addr_t a;
        n_tests  = 0;
        n_fail   = 0;
        done_cnt = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        ready    = 1'b0;
        len_in   = '0;
        tready   = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_cnt", 64'(pkt_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_pkt(9'd4, 64'd0, 0, 32'd1);
        run_pkt(9'd5, 64'hA5A5_0000_0000_0000, 1, 32'd2);
        run_pkt(9'd1, 64'h0101_0000_0000_0000, 0, 32'd3);
        run_pkt(9'd0, 64'd0, 0, 32'd4);
        run_pkt(9'd3, 64'h3300_0000_0000_0000, 0, 32'd5);
        run_pkt(9'd2, 64'h2200_0000_0000_0000, 0, 32'd6);

        // Reset during the 2nd beat of a len-8 packet
        @(negedge clk);
        t0 = cyc;
        dc = done_cnt;
        for (int i = 0; i < 8; i++) tb_mem[i] = 64'h8800_0000_0000_0000 + 64'(i);
        for (int i = 0; i < 3; i++) begin
            a.addr = 9'(i);
            a.cyc  = t0 + 1 + i;
            q_addr.push_back(a);
        end
        b.data = tb_mem[0];
        b.last = 1'b0;
        b.cyc  = t0 + 3;
        q_beat.push_back(b);
        ready  = 1'b1;
        len_in = 9'd8;
        tready = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_tvalid", 64'(tvalid), 64'd1);
        rst_n = 1'b0;
        ready = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
        chk("mid_rst_tlast", 64'(tlast), 64'd0);
        chk("mid_rst_tdata", tdata, 64'd0);
        chk("mid_rst_rd_en", 64'(rd_en), 64'd0);
        chk("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("mid_rst_done", 64'(fwd_done), 64'd0);
        chk("mid_rst_cnt", 64'(pkt_cnt), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt), 64'(dc));
        chk("rst_addr_q_empty", 64'(q_addr.size()), 64'd0);
        chk("rst_beat_q_empty", 64'(q_beat.size()), 64'd0);
        run_pkt(9'd2, 64'h7700_0000_0000_0000, 0, 32'd1);

        // Counter wrap
        @(negedge clk);
        force dut.r_pkt_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_pkt_cnt;
        chk("cnt_preload", 64'(pkt_cnt), 64'hFFFF_FFFF);
        run_pkt(9'd1, 64'h5500_0000_0000_0000, 0, 32'd0);

        repeat (4) @(negedge clk);
        chk("final_addr_q_empty", 64'(q_addr.size()), 64'd0);
        chk("final_beat_q_empty", 64'(q_beat.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
